// File: rtl/mir_fetch_stage_if.sv
// Fetch-stage bus: ROM port, control inputs from Execute/hazard unit, and the
// Operand-stage microinstruction register outputs.
interface mir_fetch_stage_if #(
  parameter int AW = 8
);
  logic          UC_enable;
  logic [32:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic [32:0]   MIR_Operand;
  logic [AW-1:0] pc_operand;
  logic          mir_valid;
  logic          stall_timeout;
  logic [7:0]    stall_cycles;

  modport master (
    input  UC_enable, rom_data, branch_taken, branch_target, halt,
    output rom_addr, MIR_Operand, pc_operand, mir_valid, stall_timeout, stall_cycles
  );

  modport slave (
    output UC_enable, rom_data, branch_taken, branch_target, halt,
    input  rom_addr, MIR_Operand, pc_operand, mir_valid, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/mir_fetch_stage.sv
// Microprogram fetch stage: micro-PC, ROM read and the MIR_Operand register,
// with stall hold, branch redirect (one bubble), halt and stall monitoring.
module mir_fetch_stage #(
  parameter int          AW          = 8,
  parameter int          STALL_LIMIT = 16,
  parameter logic [32:0] NOP_MIR     = 33'b000000000100011100011010000000000
) (
  input  logic          clk,
  input  logic          rst_n,
  mir_fetch_stage_if.master bus
);
  localparam int CW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_e;

  state_e        state, state_nxt;
  logic          do_branch, do_halt, do_stall, do_adv;
  logic [AW-1:0] upc;
  logic [32:0]   mir;
  logic [AW-1:0] pc_op;
  logic          vld;
  logic [CW-1:0] cons;
  logic          tmo;
  logic [7:0]    stc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   if (!bus.branch_taken && bus.halt) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_INIT;
    endcase
  end

  // Per-edge action decode; priority branch > halt > stall > advance.
  always_comb begin
    do_branch = 1'b0;
    do_halt   = 1'b0;
    do_stall  = 1'b0;
    do_adv    = 1'b0;
    if (state == S_RUN) begin
      if (bus.branch_taken)    do_branch = 1'b1;
      else if (bus.halt)       do_halt   = 1'b1;
      else if (!bus.UC_enable) do_stall  = 1'b1;
      else                     do_adv    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc   <= '0;
      mir   <= NOP_MIR;
      pc_op <= '0;
      vld   <= 1'b0;
    end else if (do_branch) begin
      // A stalled younger instruction is squashed along with the fall-through.
      upc <= bus.branch_target;
      mir <= NOP_MIR;
      vld <= 1'b0;
    end else if (do_halt) begin
      mir <= NOP_MIR;
      vld <= 1'b0;
    end else if (do_adv) begin
      mir   <= bus.rom_data;
      pc_op <= upc;
      vld   <= 1'b1;
      upc   <= upc + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cons <= '0;
      tmo  <= 1'b0;
      stc  <= '0;
    end else if (do_stall) begin
      if (stc != 8'hFF) stc <= stc + 8'd1;
      if (int'(cons) < STALL_LIMIT) cons <= cons + CW'(1);
      if (int'(cons) + 1 >= STALL_LIMIT) tmo <= 1'b1;
    end else if (do_branch || do_adv) begin
      cons <= '0;
    end
  end

  assign bus.rom_addr      = upc;
  assign bus.MIR_Operand   = mir;
  assign bus.pc_operand    = pc_op;
  assign bus.mir_valid     = vld;
  assign bus.stall_timeout = tmo;
  assign bus.stall_cycles  = stc;
endmodule

// File: tb/tb_mir_fetch_stage.sv
// Self-checking bench for mir_fetch_stage: directed scenarios plus random
// stimulus against a behavioural model of the fetch rules.
module tb_mir_fetch_stage;
  localparam logic [32:0] NOP = 33'b000000000100011100011010000000000;
  localparam int LIMIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  logic [32:0] rom [256];

  mir_fetch_stage_if #(.AW(8)) bus ();

  mir_fetch_stage #(.AW(8), .STALL_LIMIT(LIMIT), .NOP_MIR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  // Model state: 0 = init, 1 = run, 2 = halt.
  int          m_state;
  int          m_upc, m_pc, m_stc, m_cons;
  logic [32:0] m_mir;
  logic        m_vld, m_to;

  wire [58:0] obs = {bus.MIR_Operand, bus.pc_operand, bus.mir_valid,
                     bus.stall_timeout, bus.stall_cycles, bus.rom_addr};

  function automatic logic [58:0] exp_v();
    return {m_mir, 8'(m_pc), m_vld, m_to, 8'(m_stc), 8'(m_upc)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_upc = 0; m_pc = 0; m_stc = 0; m_cons = 0;
    m_mir = NOP; m_vld = 1'b0; m_to = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, land 1ns after the edge.
  task automatic cycle(input logic en, input logic br, input int tgt, input logic hl);
    bus.UC_enable = en;
    bus.branch_taken = br;
    bus.branch_target = 8'(tgt);
    bus.halt = hl;
    if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      if (br) begin
        m_upc = tgt % 256; m_mir = NOP; m_vld = 1'b0; m_cons = 0;
      end else if (hl) begin
        m_mir = NOP; m_vld = 1'b0; m_state = 2;
      end else if (!en) begin
        m_stc = (m_stc < 255) ? m_stc + 1 : 255;
        m_cons++;
        if (m_cons >= LIMIT) m_to = 1'b1;
      end else begin
        m_mir = rom[m_upc]; m_pc = m_upc; m_vld = 1'b1;
        m_upc = (m_upc + 1) % 256; m_cons = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.UC_enable = 1'b1; bus.branch_taken = 1'b0; bus.branch_target = '0; bus.halt = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs !== exp_v()) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", obs, exp_v());
    end
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.mir_valid !== 1'b0 || bus.rom_addr !== 8'd0) begin
      n_fail++; $display("FAIL init_no_load got vld=%b addr=%h want vld=0 addr=00",
                         bus.mir_valid, bus.rom_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 256; i++) rom[i] = 33'(i);
    apply_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 0, 1'b0);
      n_checks++;
      if (bus.MIR_Operand !== 33'(i) || bus.pc_operand !== 8'(i) || bus.mir_valid !== 1'b1
          || obs !== exp_v()) begin
        n_fail++; $display("FAIL seq_fetch[%0d] got=%h want=%h", i, obs, exp_v());
      end
    end
  endtask

  // Continues from test_sequential: MIR holds pc 5, upc is 6.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.MIR_Operand !== 33'd5 || bus.pc_operand !== 8'd5 || bus.rom_addr !== 8'd6
        || bus.stall_cycles !== 8'd3 || obs !== exp_v()) begin
      n_fail++; $display("FAIL stall_hold got=%h want=%h", obs, exp_v());
    end
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.pc_operand !== 8'd6 || bus.MIR_Operand !== 33'd6 || obs !== exp_v()) begin
      n_fail++; $display("FAIL stall_resume got=%h want=%h", obs, exp_v());
    end
  endtask

  task automatic test_branch_during_stall();
    cycle(1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 'h40, 1'b0);
    n_checks++;
    if (bus.MIR_Operand !== NOP || bus.mir_valid !== 1'b0 || obs !== exp_v()) begin
      n_fail++; $display("FAIL branch_bubble got=%h want=%h", obs, exp_v());
    end
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.MIR_Operand !== 33'h40 || bus.pc_operand !== 8'h40 || obs !== exp_v()) begin
      n_fail++; $display("FAIL branch_target got=%h want=%h", obs, exp_v());
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= LIMIT; i++) begin
      cycle(1'b0, 1'b0, 0, 1'b0);
      n_checks++;
      if (bus.stall_timeout !== (i >= LIMIT) || obs !== exp_v()) begin
        n_fail++; $display("FAIL timeout_stall[%0d] got=%h want=%h", i, obs, exp_v());
      end
    end
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.stall_timeout !== 1'b1 || obs !== exp_v()) begin
      n_fail++; $display("FAIL timeout_sticky got=%h want=%h", obs, exp_v());
    end
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.stall_cycles !== 8'd255 || obs !== exp_v()) begin
      n_fail++; $display("FAIL stall_saturate got=%h want=%h", obs, exp_v());
    end
    // Reset while stalled clears everything without waiting for an edge.
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (obs !== exp_v()) begin
      n_fail++; $display("FAIL reset_mid_stall got=%h want=%h", obs, exp_v());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    apply_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 'hFF, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.pc_operand !== 8'hFF || bus.rom_addr !== 8'h00 || obs !== exp_v()) begin
      n_fail++; $display("FAIL wrap_ff got=%h want=%h", obs, exp_v());
    end
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.pc_operand !== 8'h00 || bus.MIR_Operand !== 33'h0 || obs !== exp_v()) begin
      n_fail++; $display("FAIL wrap_00 got=%h want=%h", obs, exp_v());
    end
  endtask

  task automatic test_halt();
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (bus.MIR_Operand !== NOP || bus.mir_valid !== 1'b0 || obs !== exp_v()) begin
      n_fail++; $display("FAIL halt_enter got=%h want=%h", obs, exp_v());
    end
    cycle(1'b1, 1'b1, 'h20, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.rom_addr !== 8'h02 || bus.mir_valid !== 1'b0 || obs !== exp_v()) begin
      n_fail++; $display("FAIL halt_ignores got=%h want=%h", obs, exp_v());
    end
    apply_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (bus.mir_valid !== 1'b1 || bus.pc_operand !== 8'h00 || obs !== exp_v()) begin
      n_fail++; $display("FAIL halt_reset_exit got=%h want=%h", obs, exp_v());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) rom[i] = {1'($urandom), 32'($urandom)};
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_state == 2 && $urandom_range(0, 7) == 0) apply_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 255)), $urandom_range(0, 79) == 0);
      n_checks++;
      if (obs !== exp_v()) begin
        n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_v());
      end
    end
  endtask

  initial begin
    bus.UC_enable = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0; bus.halt = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 33'(i);
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_during_stall();
    test_timeout();
    test_wrap();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
